// File: rtl/cpu_ctrl_fsm_p_if.sv
// Control bundle between the CPU datapath and its control FSM.
// The datapath (master) supplies the instruction, flags and UART status; the FSM (slave) drives the controls.
interface cpu_ctrl_fsm_p_if;
    logic [15:0] instruction;
    logic [4:0]  flags;
    logic        tx_busy;
    logic        pc_en;
    logic        pc_rst;
    logic        pc_mux;
    logic        reg_rst;
    logic        r_en;
    logic        ls_cntl;
    logic        wb_mem_sel;
    logic        we;
    logic        ir_en;
    logic        enc_mux;
    logic [3:0]  enc_sel;
    logic        tx_reg_en;
    logic        tx_en;
    logic        tx_timeout;
    logic [3:0]  state_dbg;

    modport master (
        output instruction, flags, tx_busy,
        input  pc_en, pc_rst, pc_mux, reg_rst, r_en, ls_cntl, wb_mem_sel, we, ir_en,
               enc_mux, enc_sel, tx_reg_en, tx_en, tx_timeout, state_dbg
    );

    modport slave (
        input  instruction, flags, tx_busy,
        output pc_en, pc_rst, pc_mux, reg_rst, r_en, ls_cntl, wb_mem_sel, we, ir_en,
               enc_mux, enc_sel, tx_reg_en, tx_en, tx_timeout, state_dbg
    );
endinterface

// File: rtl/cpu_ctrl_fsm_p.sv
// Multi-cycle control FSM for the 16-bit CPU with N encoder channels,
// configurable load wait-states and a transmit stall with timeout/skip. Outputs are Moore.
module cpu_ctrl_fsm_p #(
    parameter int NUM_ENC    = 2,
    parameter int LOAD_WAIT  = 0,
    parameter int TX_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    cpu_ctrl_fsm_p_if.slave bus
);
    typedef enum logic [3:0] {
        S_STARTUP   = 4'd0,  S_FETCH     = 4'd1,  S_DECODE  = 4'd2,  S_ALU_WB  = 4'd3,
        S_STORE     = 4'd4,  S_LOAD_ADDR = 4'd5,  S_LOAD_WT = 4'd6,  S_LOAD_WB = 4'd7,
        S_BR_TAKE   = 4'd8,  S_ADV       = 4'd9,  S_CMP     = 4'd10, S_ENC_RD  = 4'd11,
        S_TX_WAIT   = 4'd12, S_TX_LOAD   = 4'd13, S_TX_FIRE = 4'd14, S_TX_SKIP = 4'd15
    } state_t;

    localparam logic [2:0] LD_LAST = (LOAD_WAIT  == 0) ? 3'd0 : 3'(LOAD_WAIT - 1);
    localparam logic [7:0] TX_LAST = (TX_TIMEOUT == 0) ? 8'd0 : 8'(TX_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [2:0] ld_cnt;
    logic [7:0] tx_cnt;
    logic [3:0] ch_q;

    logic [3:0] op, cond, ext, ch;
    logic       z, n, br_taken, ch_ok;
    logic       unused_flags;

    assign op   = bus.instruction[15:12];
    assign cond = bus.instruction[11:8];
    assign ext  = bus.instruction[7:4];
    assign ch   = bus.instruction[3:0];
    assign z    = bus.flags[3];
    assign n    = bus.flags[1];
    assign unused_flags = ^{bus.flags[4], bus.flags[2], bus.flags[0]};

    assign br_taken = (cond == 4'b0000 &&  z) ||
                      (cond == 4'b0001 && !z) ||
                      (cond == 4'b1100 && !z && n) ||
                      (cond == 4'b1110);
    assign ch_ok    = ({1'b0, ch} < 5'(NUM_ENC));

    // Counters run only while in their wait state, so entering it always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_STARTUP;
            ld_cnt <= '0;
            tx_cnt <= '0;
            ch_q   <= '0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= (state == S_LOAD_WT) ? ld_cnt + 3'd1 : 3'd0;
            tx_cnt <= (state == S_TX_WAIT) ? tx_cnt + 8'd1 : 8'd0;
            if (state == S_DECODE)
                ch_q <= ch;
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.pc_en      = 1'b0;
        bus.pc_rst     = 1'b0;
        bus.pc_mux     = 1'b0;
        bus.reg_rst    = 1'b0;
        bus.r_en       = 1'b0;
        bus.ls_cntl    = 1'b1;
        bus.wb_mem_sel = 1'b0;
        bus.we         = 1'b0;
        bus.ir_en      = 1'b0;
        bus.enc_mux    = 1'b0;
        bus.enc_sel    = 4'd0;
        bus.tx_reg_en  = 1'b0;
        bus.tx_en      = 1'b0;
        bus.tx_timeout = 1'b0;

        unique case (state)
            S_STARTUP: begin
                bus.pc_rst  = 1'b1;
                bus.reg_rst = 1'b1;
                bus.ls_cntl = 1'b0;
                state_nxt   = S_FETCH;
            end
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                bus.ir_en = 1'b1;
                if (op == 4'b0100 && ext == 4'b0000)
                    state_nxt = S_LOAD_ADDR;
                else if (op == 4'b0100 && ext == 4'b0100)
                    state_nxt = S_STORE;
                else if (op == 4'b1100)
                    state_nxt = br_taken ? S_BR_TAKE : S_ADV;
                else if ((op == 4'b0000 && ext == 4'b1011) || op == 4'b1011)
                    state_nxt = S_CMP;
                else if (op == 4'b1000 && ext == 4'b1100)
                    state_nxt = ch_ok ? S_ENC_RD : S_ADV;
                else if (op == 4'b1000 && ext == 4'b1111)
                    state_nxt = bus.tx_busy ? S_TX_WAIT : S_TX_LOAD;
                else
                    state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                bus.pc_en = 1'b1;
                bus.r_en  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                bus.pc_en   = 1'b1;
                bus.we      = 1'b1;
                bus.ls_cntl = 1'b0;
                state_nxt   = S_FETCH;
            end
            S_LOAD_ADDR: begin
                bus.ls_cntl = 1'b0;
                state_nxt   = (LOAD_WAIT == 0) ? S_LOAD_WB : S_LOAD_WT;
            end
            S_LOAD_WT: begin
                bus.ls_cntl = 1'b0;
                if (ld_cnt == LD_LAST)
                    state_nxt = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                bus.pc_en      = 1'b1;
                bus.r_en       = 1'b1;
                bus.wb_mem_sel = 1'b1;
                bus.ls_cntl    = 1'b0;
                state_nxt      = S_FETCH;
            end
            S_BR_TAKE: begin
                bus.pc_en  = 1'b1;
                bus.pc_mux = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ADV, S_CMP: begin
                bus.pc_en = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ENC_RD: begin
                bus.pc_en   = 1'b1;
                bus.r_en    = 1'b1;
                bus.enc_mux = 1'b1;
                bus.enc_sel = ch_q;
                state_nxt   = S_FETCH;
            end
            // A released transmitter wins over a timeout landing in the same cycle.
            S_TX_WAIT: begin
                if (!bus.tx_busy)
                    state_nxt = S_TX_LOAD;
                else if (TX_TIMEOUT != 0 && tx_cnt == TX_LAST)
                    state_nxt = S_TX_SKIP;
            end
            S_TX_LOAD: begin
                bus.tx_reg_en = 1'b1;
                state_nxt     = S_TX_FIRE;
            end
            S_TX_FIRE: begin
                bus.pc_en = 1'b1;
                bus.tx_en = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TX_SKIP: begin
                bus.pc_en      = 1'b1;
                bus.tx_timeout = 1'b1;
                state_nxt      = S_FETCH;
            end
            default: state_nxt = S_STARTUP;
        endcase
    end

    assign bus.state_dbg = state;
endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// Bench for cpu_ctrl_fsm_p: directed vector table, hand-written reset/abort sequences,
// and random instructions checked cycle by cycle against a sequence-level reference model.
module tb_cpu_ctrl_fsm_p;
    localparam int NUM_ENC = 4;
    localparam int LW      = 2;
    localparam int TXT     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_p_if bus();

    cpu_ctrl_fsm_p #(.NUM_ENC(NUM_ENC), .LOAD_WAIT(LW), .TX_TIMEOUT(TXT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    logic [16:0] obs_v;
    assign obs_v = {bus.pc_en, bus.pc_rst, bus.pc_mux, bus.reg_rst, bus.r_en, bus.ls_cntl,
                    bus.wb_mem_sel, bus.we, bus.ir_en, bus.enc_mux, bus.enc_sel,
                    bus.tx_reg_en, bus.tx_en, bus.tx_timeout};

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [4:0]  flags;
        int          busy;
        int          exec_st;
        int          cycles;
        int          n_r_en;
        int          n_we;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output vector each state must present, taken from the output assertion list.
    function automatic logic [16:0] exp_out(input int s, input logic [3:0] ch);
        logic [16:0] v;
        v = {(s inside {3, 4, 7, 8, 9, 10, 11, 14, 15}), (s == 0), (s == 8), (s == 0),
             (s inside {3, 7, 11}), !(s inside {0, 4, 5, 6, 7}), (s == 7), (s == 4),
             (s == 2), (s == 11), ((s == 11) ? ch : 4'h0), (s == 13), (s == 14), (s == 15)};
        return v;
    endfunction

    // Expected state trace of one instruction, from FETCH to its last state.
    task automatic build_model(input logic [15:0] ins, input logic [4:0] fl, input int busy);
        logic [3:0] op, cond, ext, ch;
        logic       z, n, taken;
        op = ins[15:12]; cond = ins[11:8]; ext = ins[7:4]; ch = ins[3:0];
        z = fl[3]; n = fl[1];
        exp_q = {1, 2};
        if (op == 4'h4 && ext == 4'h0) begin
            exp_q.push_back(5);
            repeat (LW) exp_q.push_back(6);
            exp_q.push_back(7);
        end else if (op == 4'h4 && ext == 4'h4) begin
            exp_q.push_back(4);
        end else if (op == 4'hC) begin
            taken = (cond == 4'h0 && z) || (cond == 4'h1 && !z) ||
                    (cond == 4'hC && !z && n) || (cond == 4'hE);
            exp_q.push_back(taken ? 8 : 9);
        end else if ((op == 4'h0 && ext == 4'hB) || op == 4'hB) begin
            exp_q.push_back(10);
        end else if (op == 4'h8 && ext == 4'hC) begin
            exp_q.push_back((int'(ch) < NUM_ENC) ? 11 : 9);
        end else if (op == 4'h8 && ext == 4'hF) begin
            if (busy <= TXT) begin
                repeat (busy) exp_q.push_back(12);
                exp_q.push_back(13);
                exp_q.push_back(14);
            end else begin
                repeat (TXT) exp_q.push_back(12);
                exp_q.push_back(15);
            end
        end else begin
            exp_q.push_back(3);
        end
    endtask

    // tx_busy is high for 'busy' cycles starting with DECODE (cycle index 1).
    task automatic drive_busy(input int i, input int busy);
        bus.tx_busy = (i >= 1 && i - 1 < busy);
    endtask

    // Entered and left at a negedge with the FSM in FETCH.
    task automatic run_model(input string nm, input logic [15:0] ins, input logic [4:0] fl,
                             input int busy);
        build_model(ins, fl, busy);
        bus.instruction = ins;
        bus.flags       = fl;
        foreach (exp_q[i]) begin
            drive_busy(i, busy);
            check({nm, "_state"}, 32'(bus.state_dbg), 32'(exp_q[i]));
            check({nm, "_outs"}, 32'(obs_v), 32'(exp_out(exp_q[i], ins[3:0])));
            @(negedge clk);
        end
        bus.tx_busy = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int last, npc, nr, nwe, i;
        bit done;
        last = -1; npc = 0; nr = 0; nwe = 0; done = 0;
        bus.instruction = v.instr;
        bus.flags       = v.flags;
        for (i = 0; i < 40; i++) begin
            drive_busy(i, v.busy);
            if (i > 0 && bus.state_dbg == 4'd1) begin
                done = 1;
                break;
            end
            last = int'(bus.state_dbg);
            npc += int'(bus.pc_en);
            nr  += int'(bus.r_en);
            nwe += int'(bus.we);
            @(negedge clk);
        end
        bus.tx_busy = 1'b0;
        check({v.name, "_done"}, 32'(done), 32'd1);
        check({v.name, "_exec"}, 32'(last), 32'(v.exec_st));
        check({v.name, "_cycles"}, 32'(i), 32'(v.cycles));
        check({v.name, "_pc_en"}, 32'(npc), 32'd1);
        check({v.name, "_r_en"}, 32'(nr), 32'(v.n_r_en));
        check({v.name, "_we"}, 32'(nwe), 32'(v.n_we));
    endtask

    function automatic void add(input string nm, input logic [15:0] ins, input logic [4:0] fl,
                                input int busy, input int st, input int cyc, input int r,
                                input int w);
        vec_t v;
        v = '{nm, ins, fl, busy, st, cyc, r, w};
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins;
        logic [4:0]  fl;
        int          busy;

        // Expected: exec state, cycles FETCH..last, r_en pulses, we pulses
        add("add",       16'h0152, 5'b00000, 0, 3, 3, 1, 0);
        add("load",      16'h4102, 5'b00000, 0, 7, 6, 1, 0);
        add("store",     16'h4142, 5'b00000, 0, 4, 3, 0, 1);
        add("beq_t",     16'hC005, 5'b01000, 0, 8, 3, 0, 0);
        add("beq_n",     16'hC005, 5'b00000, 0, 9, 3, 0, 0);
        add("bne_t",     16'hC105, 5'b00000, 0, 8, 3, 0, 0);
        add("blt_t",     16'hCC05, 5'b00010, 0, 8, 3, 0, 0);
        add("blt_n",     16'hCC05, 5'b01010, 0, 9, 3, 0, 0);
        add("bal",       16'hCE00, 5'b00000, 0, 8, 3, 0, 0);
        add("cmp_r",     16'h00B3, 5'b00000, 0, 10, 3, 0, 0);
        add("cmp_i",     16'hB123, 5'b00000, 0, 10, 3, 0, 0);
        add("enc_in",    16'h81C2, 5'b00000, 0, 11, 3, 1, 0);
        add("enc_edge",  16'h81C3, 5'b00000, 0, 11, 3, 1, 0);
        add("enc_out",   16'h81C5, 5'b00000, 0, 9, 3, 0, 0);
        add("tx_free",   16'h81F0, 5'b00000, 0, 14, 4, 0, 0);
        add("tx_busy3",  16'h81F0, 5'b00000, 3, 14, 7, 0, 0);
        add("tx_busy4",  16'h81F0, 5'b00000, 4, 14, 8, 0, 0);
        add("tx_skip",   16'h81F0, 5'b00000, 20, 15, 7, 0, 0);
        add("ri_other",  16'h40C0, 5'b00000, 0, 3, 3, 1, 0);

        bus.instruction = 16'h0000;
        bus.flags       = 5'b0;
        bus.tx_busy     = 1'b0;

        // Reset held for 3 cycles, then sequence 0,1,2 from release
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_state", 32'(bus.state_dbg), 32'd0);
            check("rst_outs", 32'(obs_v), 32'(exp_out(0, 4'h0)));
        end
        rst = 1'b0;
        check("rel_state", 32'(bus.state_dbg), 32'd0);
        @(negedge clk);
        run_model("first", 16'h0152, 5'b0, 0);

        foreach (vecs[k]) run_vec(vecs[k]);

        run_model("m_load",  16'h4102, 5'b0, 0);
        run_model("m_enc",   16'h81C2, 5'b0, 0);
        run_model("m_enc_x", 16'h81C5, 5'b0, 0);
        run_model("m_tx3",   16'h81F0, 5'b0, 3);
        run_model("m_txto",  16'h81F0, 5'b0, 9);

        // Async reset during the 2nd LOAD_WAIT cycle aborts the load
        bus.instruction = 16'h4102;
        for (int i = 0; i < 5; i++) begin
            check("abort_pre", 32'(bus.state_dbg), 32'((i < 3) ? i + 1 + ((i == 2) ? 2 : 0) : 6));
            if (i < 4) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("abort_async", 32'(bus.state_dbg), 32'd0);
        check("abort_outs", 32'(obs_v), 32'(exp_out(0, 4'h0)));
        repeat (2) begin
            @(negedge clk);
            check("abort_hold", 32'({bus.r_en, bus.pc_en, bus.we, bus.state_dbg}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        run_model("post_abort", 16'h0152, 5'b0, 0);

        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 7))
                0: ins = {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
                1: ins = {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
                2: ins = {4'hC, ($urandom_range(0, 1) == 1) ? 4'($urandom) :
                          (($urandom_range(0, 1) == 1) ? 4'hC : 4'h1), 8'($urandom)};
                3: ins = ($urandom_range(0, 1) == 1) ? {4'hB, 12'($urandom)} :
                         {4'h0, 4'($urandom), 4'hB, 4'($urandom)};
                4: ins = {4'h8, 4'($urandom), 4'hC, 4'($urandom)};
                5: ins = {4'h8, 4'($urandom), 4'hF, 4'($urandom)};
                default: ins = 16'($urandom);
            endcase
            fl   = 5'($urandom);
            busy = $urandom_range(0, 6);
            run_model("rand", ins, fl, busy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
